bitrev_copy_ctrl: RTL and testbench

- Consumes the bit-reversed address stream from the FFT address generator and performs the reorder copy between the ping-pong banks.
- For each natural index k it reads bank0[k] and writes the result into bank1 at the incoming address, so that bank1[bitrev(k)] = bank0[k].
- Sits between the bit-reversal address generator and the first butterfly stage.
- When the copy completes, bank1 holds the reordered samples and the butterfly controller is released via done.

---
 rtl/fft_pkg.sv | 25 ++
 rtl/bitrev_dup_check.sv | 40 ++++
 rtl/bitrev_copy_ctrl.sv | 118 +++++++++++
 tb/tb_bitrev_copy_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared FFT definitions: default geometry, the reorder-copy FSM encoding,
// and the bit-reversal helper used to build golden address streams.
package fft_pkg;

   localparam int N_DEF            = 8;
   localparam int BITS_PER_ROW_DEF = 3;
   localparam int DATA_W_DEF       = 32;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_COPY  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } copy_state_e;

   function automatic int unsigned bitrev(input int unsigned k, input int unsigned bits);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < bits; i++) begin
         r = (r << 1) | ((k >> i) & 1);
      end
      return r;
   endfunction

endpackage

// File: rtl/bitrev_dup_check.sv
// Per-pass bitmap of destination addresses already written; flags a hit when
// an accepted address has been seen earlier in the same pass.
module bitrev_dup_check
   import fft_pkg::*;
#(
   parameter int N            = N_DEF,
   parameter int BITS_PER_ROW = BITS_PER_ROW_DEF
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    clear,
   input  logic                    set,
   input  logic [BITS_PER_ROW-1:0] addr,
   output logic                    hit
);

   logic [N-1:0] bitmap_q;
   logic [N-1:0] bitmap_d;

   always_comb begin
      bitmap_d = bitmap_q;
      if (clear) begin
         bitmap_d = '0;
      end else if (set) begin
         bitmap_d[addr] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bitmap_q <= '0;
      end else begin
         bitmap_q <= bitmap_d;
      end
   end

   // Hit looks at the bitmap before this accept's own bit is set.
   assign hit = set & ~clear & bitmap_q[addr];

endmodule

// File: rtl/bitrev_copy_ctrl.sv
// Reorder copy between ping-pong banks: reads bank0 in natural order and writes
// each sample to bank1 at the bit-reversed address supplied by the generator.
module bitrev_copy_ctrl
   import fft_pkg::*;
#(
   parameter int N            = N_DEF,
   parameter int BITS_PER_ROW = BITS_PER_ROW_DEF,
   parameter int DATA_W       = DATA_W_DEF
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic [BITS_PER_ROW-1:0] addr_in,
   input  logic                    addr_valid,
   output logic                    addr_ready,
   output logic                    rd_en,
   output logic [BITS_PER_ROW-1:0] rd_addr,
   input  logic [DATA_W-1:0]       rd_data,
   output logic                    wr_en,
   output logic [BITS_PER_ROW-1:0] wr_addr,
   output logic [DATA_W-1:0]       wr_data,
   output logic                    busy,
   output logic                    done,
   output logic                    err_dup
);

   localparam int              CW   = BITS_PER_ROW + 1;
   localparam logic [CW-1:0]   LAST = CW'(N - 1);

   copy_state_e             state_q;
   copy_state_e             state_d;
   logic [CW-1:0]           cnt_q;
   logic [CW-1:0]           cnt_d;
   logic                    wr_en_q;
   logic                    wr_en_d;
   logic [BITS_PER_ROW-1:0] wr_addr_q;
   logic [BITS_PER_ROW-1:0] wr_addr_d;
   logic                    err_dup_q;
   logic                    err_dup_d;
   logic                    accept;
   logic                    start_ok;
   logic                    dup_hit;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (start) state_d = ST_COPY;
         ST_COPY:  if (accept && (cnt_q == LAST)) state_d = ST_DRAIN;
         ST_DRAIN: state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      addr_ready = (state_q == ST_COPY);
      busy       = (state_q == ST_COPY) || (state_q == ST_DRAIN);
      done       = (state_q == ST_DONE);
      start_ok   = start && (state_q == ST_IDLE);
      accept     = addr_valid && addr_ready;
      rd_en      = accept;
      rd_addr    = accept ? cnt_q[BITS_PER_ROW-1:0] : '0;
   end

   // The write stage trails each accept by one cycle, lining up with rd_data.
   always_comb begin
      cnt_d     = cnt_q;
      wr_en_d   = accept;
      wr_addr_d = accept ? addr_in : '0;
      err_dup_d = err_dup_q | dup_hit;
      if (start_ok) begin
         cnt_d     = '0;
         err_dup_d = 1'b0;
      end else if (accept) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q     <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         err_dup_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         err_dup_q <= err_dup_d;
      end
   end

   assign wr_en   = wr_en_q;
   assign wr_addr = wr_addr_q;
   assign wr_data = wr_en_q ? rd_data : '0;
   assign err_dup = err_dup_q;

   bitrev_dup_check #(
      .N            (N),
      .BITS_PER_ROW (BITS_PER_ROW)
   ) u_dup_check (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (start_ok),
      .set   (accept),
      .addr  (addr_in),
      .hit   (dup_hit)
   );

endmodule

// File: tb/tb_bitrev_copy_ctrl.sv
// Self-checking bench for bitrev_copy_ctrl: table-driven passes, hand-written
// reset sequence and randomized passes against a bank-level reference model.
module tb_bitrev_copy_ctrl;
   import fft_pkg::*;

   localparam int N  = 8;
   localparam int AW = 3;
   localparam int DW = 32;

   logic          clk        = 1'b0;
   logic          rst_n      = 1'b0;
   logic          start      = 1'b0;
   logic [AW-1:0] addr_in    = '0;
   logic          addr_valid = 1'b0;
   logic          addr_ready;
   logic          rd_en;
   logic [AW-1:0] rd_addr;
   logic [DW-1:0] rd_data    = '0;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic          busy;
   logic          done;
   logic          err_dup;

   bitrev_copy_ctrl #(.N(N), .BITS_PER_ROW(AW), .DATA_W(DW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .addr_in    (addr_in),
      .addr_valid (addr_valid),
      .addr_ready (addr_ready),
      .rd_en      (rd_en),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .busy       (busy),
      .done       (done),
      .err_dup    (err_dup)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [N-1:0][AW-1:0] addrs;
      int                   bubbleMode;
      bit                   overSupply;
      bit                   midStart;
      bit                   startInDone;
      bit                   expErrDup;
   } vec_t;

   int            passCount  = 0;
   int            checkCount = 0;
   int            cyc        = 0;
   bit            monEnable  = 0;
   int            monAcc, wrCount, doneCount, lastWrCycle, doneCycle, prevK;
   bit            prevAcc;
   logic [AW-1:0] prevAddr;
   logic [DW-1:0] bank0 [N];
   logic [DW-1:0] bank1 [N];
   bit            bank1Wr [N];

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checkCount++;
      if (actual === expected) passCount++;
      else $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
   endtask

   always @(posedge clk) cyc++;

   // Bank0 memory model: synchronous read, data valid one cycle after rd_en.
   always @(posedge clk) if (rd_en) rd_data <= bank0[rd_addr];

   // Cycle monitor: handshake rules, write-stage alignment and bank1 capture.
   always @(negedge clk) begin
      if (monEnable) begin
         bit accNow;
         accNow = addr_valid && addr_ready;
         checkOutput("addr_ready", addr_ready, busy && (monAcc < N));
         checkOutput("rd_en", rd_en, accNow);
         if (accNow) begin
            checkOutput("rd_addr", rd_addr, monAcc);
            checkOutput("busy_on_accept", busy, 1);
         end
         checkOutput("wr_en_follows_accept", wr_en, prevAcc);
         if (wr_en) begin
            checkOutput("wr_addr", wr_addr, prevAddr);
            checkOutput("wr_data", wr_data, bank0[prevK]);
            bank1[wr_addr]   = wr_data;
            bank1Wr[wr_addr] = 1;
            wrCount++;
            lastWrCycle = cyc;
         end
         if (done) begin
            doneCount++;
            doneCycle = cyc;
            checkOutput("busy_in_done", busy, 0);
         end
         prevAcc  = accNow;
         prevAddr = addr_in;
         prevK    = monAcc;
         if (accNow) monAcc++;
      end
   end

   function automatic bit refHasDup(input logic [N-1:0][AW-1:0] a);
      bit seen [N];
      bit dup;
      dup = 0;
      for (int i = 0; i < N; i++) seen[i] = 0;
      for (int k = 0; k < N; k++) begin
         if (seen[a[k]]) dup = 1;
         seen[a[k]] = 1;
      end
      return dup;
   endfunction

   task automatic applyStimulus(input vec_t v, input bit randomData);
      int            i;
      int            budget;
      bit            toggle;
      bit            valid;
      logic [DW-1:0] refMem [N];
      bit            refWr [N];
      for (int k = 0; k < N; k++) begin
         bank0[k]   = randomData ? $urandom : (32'h100 + k);
         bank1[k]   = '0;
         bank1Wr[k] = 0;
      end
      monAcc = 0; wrCount = 0; doneCount = 0; lastWrCycle = -1; doneCycle = -1;
      prevAcc = 0; prevK = 0; prevAddr = '0;
      monEnable = 1;
      @(posedge clk); #1 start = 1;
      @(posedge clk); #1 start = 0;
      i = 0; budget = 0; toggle = 0;
      while (i < N && budget < 200) begin
         case (v.bubbleMode)
            1:       begin valid = toggle; toggle = !toggle; end
            2:       valid = 1'($urandom_range(0, 1));
            default: valid = 1;
         endcase
         addr_valid = valid;
         addr_in    = valid ? v.addrs[i] : AW'($urandom);
         if (v.midStart && i == 4) start = 1;
         @(negedge clk);
         if (addr_valid && addr_ready) i++;
         @(posedge clk); #1;
         start = 0;
         budget++;
      end
      if (i < N) checkOutput("stream_accept_budget", i, N);
      if (v.overSupply) begin
         repeat (4) begin
            addr_valid = 1;
            addr_in    = AW'($urandom);
            @(posedge clk); #1;
         end
      end
      addr_valid = 0;
      if (v.startInDone) begin
         budget = 0;
         while (done !== 1'b1 && budget < 40) begin
            @(negedge clk);
            budget++;
         end
         start = 1;
         @(posedge clk); #1 start = 0;
      end
      budget = 0;
      while (doneCount == 0 && budget < 40) begin
         @(posedge clk);
         budget++;
      end
      if (doneCount == 0) checkOutput("done_timeout", 0, 1);
      repeat (3) @(posedge clk);
      #1;
      monEnable = 0;
      checkOutput("busy_idle_after_pass", busy, 0);

      for (int a = 0; a < N; a++) refWr[a] = 0;
      for (int k = 0; k < N; k++) begin
         refMem[v.addrs[k]] = bank0[k];
         refWr[v.addrs[k]]  = 1;
      end
      checkOutput("write_count", wrCount, N);
      checkOutput("done_count", doneCount, 1);
      checkOutput("done_after_last_write", doneCycle, lastWrCycle + 1);
      checkOutput("err_dup", err_dup, v.expErrDup);
      for (int a = 0; a < N; a++) begin
         checkOutput("bank1_written", bank1Wr[a], refWr[a]);
         if (refWr[a]) checkOutput("bank1_data", bank1[a], refMem[a]);
      end
   endtask

   vec_t vecs [6];
   vec_t base;
   vec_t rv;

   initial begin
      for (int k = 0; k < N; k++) base.addrs[k] = AW'(bitrev(k, AW));
      base.bubbleMode = 0; base.overSupply = 0; base.midStart = 0;
      base.startInDone = 0; base.expErrDup = 0;

      vecs[0] = base;
      vecs[1] = base; vecs[1].bubbleMode = 1;
      vecs[2] = base; vecs[2].addrs[7] = 3'd3; vecs[2].expErrDup = 1;
      vecs[3] = base; vecs[3].overSupply = 1; vecs[3].midStart = 1;
      vecs[4] = base; vecs[4].addrs[1] = 3'd0; vecs[4].midStart = 1;
      vecs[4].bubbleMode = 1; vecs[4].expErrDup = 1;
      vecs[5] = base; vecs[5].startInDone = 1;

      #3;
      checkOutput("reset_addr_ready", addr_ready, 0);
      checkOutput("reset_rd_en", rd_en, 0);
      checkOutput("reset_wr_en", wr_en, 0);
      checkOutput("reset_busy", busy, 0);
      checkOutput("reset_done", done, 0);
      checkOutput("reset_err_dup", err_dup, 0);
      @(negedge clk); rst_n = 1;
      repeat (2) @(posedge clk);
      #1;

      for (int t = 0; t < 6; t++) begin
         $display("[TB] table pass %0d", t);
         applyStimulus(vecs[t], 0);
      end

      // Reset mid-pass: duplicate seen and a write pending when rst_n drops.
      @(posedge clk); #1 start = 1;
      @(posedge clk); #1 start = 0;
      addr_valid = 1; addr_in = 3'd0;
      @(posedge clk); #1 addr_in = 3'd0;
      @(posedge clk); #1 addr_in = 3'd1;
      @(posedge clk); #1;
      checkOutput("pre_reset_wr_en", wr_en, 1);
      checkOutput("pre_reset_err_dup", err_dup, 1);
      checkOutput("pre_reset_busy", busy, 1);
      rst_n = 0;
      #1;
      checkOutput("async_reset_addr_ready", addr_ready, 0);
      checkOutput("async_reset_rd_en", rd_en, 0);
      checkOutput("async_reset_wr_en", wr_en, 0);
      checkOutput("async_reset_wr_data", wr_data, 0);
      checkOutput("async_reset_busy", busy, 0);
      checkOutput("async_reset_err_dup", err_dup, 0);
      addr_valid = 0;
      @(negedge clk); rst_n = 1;
      @(posedge clk); #1;
      checkOutput("idle_after_reset", busy, 0);
      applyStimulus(base, 0);

      for (int r = 0; r < 6; r++) begin
         rv = base;
         rv.bubbleMode = 2;
         if (r % 2 == 0) begin
            for (int k = N - 1; k > 0; k--) begin
               int            j;
               logic [AW-1:0] tmp;
               j = int'($urandom_range(0, k));
               tmp = rv.addrs[k]; rv.addrs[k] = rv.addrs[j]; rv.addrs[j] = tmp;
            end
         end else begin
            for (int k = 0; k < N; k++) rv.addrs[k] = AW'($urandom);
         end
         rv.expErrDup = refHasDup(rv.addrs);
         $display("[TB] random pass %0d", r);
         applyStimulus(rv, 1);
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
